// File: rtl/param_fifo_pkg.sv
// param_fifo_pkg: shared constants and helpers for the parametrised FIFO.
//   clog2      - ceiling log2, usable in constant expressions
//   ptr_width  - pointer/count width for a given depth (address bits + 1)
//   DEFAULT_*  - default depth and threshold settings
package param_fifo_pkg;

  localparam int DEFAULT_DEPTH     = 16;
  localparam int DEFAULT_AE_THRESH = 2;
  // almost_full defaults to this many entries below full
  localparam int DEFAULT_AF_MARGIN = 2;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // One extra pointer bit tells a full FIFO apart from an empty one, and the
  // same width holds the occupancy range 0..DEPTH.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// param_fifo_mem: DEPTH x WIDTH storage array for param_fifo.
//   clk      in   clock, rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  asynchronous read data, mem[rd_addr]
// The array is deliberately not reset; the FIFO pointers define which
// entries are valid.
module param_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// param_fifo: parametrised single-clock synchronous FIFO.
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   wr_en, in           write request and write data
//   rd_en, out          read request and read data
//   empty, full         occupancy == 0 / == DEPTH
//   almost_full         count >= AF_THRESH
//   almost_empty        count <= AE_THRESH
//   count               occupancy 0..DEPTH
//   overflow/underflow  one-cycle pulse after a rejected write/read
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads
// (head word visible on out without rd_en). Default is registered read.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - DEFAULT_AF_MARGIN,
  parameter int AE_THRESH = DEFAULT_AE_THRESH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            in,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            out,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [ptr_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wptr_reg, wptr_next;
  logic [PW-1:0]    rptr_reg, rptr_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             wr_accept, rd_accept;
  logic [WIDTH-1:0] rd_data;

  param_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_accept),
    .wr_addr(wptr_reg[AW-1:0]),
    .wr_data(in),
    .rd_addr(rptr_reg[AW-1:0]),
    .rd_data(rd_data)
  );

  // Status depends on the registered pointers only; modulo subtraction
  // handles pointer wrap.
  assign count        = wptr_reg - rptr_reg;
  assign empty        = (count == '0);
  assign full         = (count == PW'(DEPTH));
  assign almost_full  = (count >= PW'(AF_THRESH));
  assign almost_empty = (count <= PW'(AE_THRESH));

  always_comb begin
    // A full FIFO still takes a write when a read frees the head slot on the
    // same edge; the array reads the old head before the write lands.
    wr_accept      = wr_en && (!full || rd_en);
    rd_accept      = rd_en && !empty;
    wptr_next      = wptr_reg + PW'(wr_accept);
    rptr_next      = rptr_reg + PW'(rd_accept);
    out_next       = rd_accept ? rd_data : out_reg;
    overflow_next  = wr_en && !wr_accept;
    underflow_next = rd_en && !rd_accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      out_reg       <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      out_reg       <= out_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

`ifdef FIFO_FWFT_EN
  // Head word falls through; out_reg keeps the last popped word so out holds
  // steady while the FIFO is empty.
  assign out = empty ? out_reg : rd_data;
`else
  assign out = out_reg;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: randomized and directed checks of param_fifo (WIDTH=8,
// DEPTH=16) against a queue-based reference model with a scoreboard.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       empty, full, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  always #5 clk = ~clk;

  param_fifo #(
    .WIDTH    (8),
    .DEPTH    (16),
    .AF_THRESH(14),
    .AE_THRESH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .in          (din),
    .rd_en       (rd_en),
    .out         (dout),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: the FIFO contents as a plain queue.
  logic [7:0] model_q[$];
  // Scoreboard: words popped by accepted reads, awaiting the monitor.
  logic [7:0] sb_q[$];
  logic [7:0] last_out = 8'h00;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One transaction: drive on the falling edge, update the model right
  // after the rising edge from its pre-edge occupancy.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    int  n;
    bit  wa, ra;
    @(negedge clk);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    n  = model_q.size();
    wa = w && (n < 16 || r);
    ra = r && (n > 0);
    if (ra) sb_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    exp_ovf = w && !wa;
    exp_unf = r && !ra;
    $display("txn wr=%0b din=%02h rd=%0b wr_ok=%0b rd_ok=%0b occupancy=%0d",
             w, d, r, wa, ra, model_q.size());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out"}, dout, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ae"}, almost_empty, 1);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_unf"}, underflow, 0);
  endtask

  // Monitor: compares DUT outputs with the model every falling edge.
  always @(negedge clk) begin : monitor
    int         n;
    logic [7:0] exp_o;
    if (mon_en && !rst) begin
      n = model_q.size();
      if (sb_q.size() > 0) last_out = sb_q.pop_front();
`ifdef FIFO_FWFT_EN
      exp_o = (n > 0) ? model_q[0] : last_out;
`else
      exp_o = last_out;
`endif
      chk("out", dout, exp_o);
      chk("count", count, n);
      chk("empty", empty, n == 0);
      chk("full", full, n == 16);
      chk("almost_full", almost_full, n >= 14);
      chk("almost_empty", almost_empty, n <= 2);
      chk("overflow", overflow, exp_ovf);
      chk("underflow", underflow, exp_unf);
    end
  end

  initial begin
    #12;
    chk_reset_outputs("por");
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Fill, then one write too many, then idle so the pulse must clear.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);

    // Drain, then one read too many.
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    // Wrap-around.
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00, 1'b1);

    // Simultaneous access at full, then at empty.
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h3C, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    // Reset in the middle of a cycle with 7 entries held.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
    @(negedge clk);
    #2;
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    model_q.delete();
    sb_q.delete();
    last_out = 8'h00;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    // Random traffic, biased write-heavy then read-heavy to visit both ends.
    for (int i = 0; i < 300; i++) begin
      int wp;
      wp = (i % 100 < 50) ? 75 : 25;
      cyc($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < (100 - wp));
    end

    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
# param_fifo

Parametrised single-clock synchronous FIFO; the next generation of the team's fixed 8-bit FIFO. Generalises data width and depth, adds programmable almost-full/almost-empty thresholds, an occupancy count and one-cycle overflow/underflow error pulses. It sits between any producer and consumer in the same clock domain. A compile-time macro selects first-word-fall-through read behaviour.

## Interface
- WIDTH, 8: data width in bits, ≥1
- DEPTH, 16: number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2: almost_full asserted when count ≥ AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2: almost_empty asserted when count ≤ AE_THRESH; legal range 0..DEPTH-1

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- in  in  WIDTH  write data
- rd_en  in  1  read request
- out  out  WIDTH  read data
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  AW+1  occupancy, 0..DEPTH; AW = clog2(DEPTH)
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Storage: DEPTH×WIDTH array. Write and read pointers are AW+1 bits; the low AW bits address the array, and the MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH with natural binary overflow.
- count = wptr − rptr, computed modulo 2^(AW+1).
- empty, full, almost_* and count are combinational functions of the registered pointers only, never of wr_en or rd_en.
- Write is accepted when wr_en && (!full || rd_en). An accepted write stores in at wptr and increments wptr.
- Read is accepted when rd_en && !empty. An accepted read increments rptr.
- Standard mode: an accepted read registers mem[rptr] into out on the same edge. Otherwise out holds its value.
- Simultaneous wr_en && rd_en:
  - When full: both are accepted, count stays DEPTH, and overflow is not asserted.
  - When empty: only the write is accepted, the read is rejected, underflow pulses, and count becomes 1.
- wr_en while full and !rd_en: data is dropped and overflow = 1 for the following cycle.
- rd_en while empty: underflow = 1 for the following cycle and out is unchanged.
- overflow and underflow are registered and cleared every cycle in which no rejection occurs.

## Timing
- Reset values (asynchronous, immediate): out=0, wptr=rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Array contents are not reset.
- Asserting rst mid-operation discards all contents immediately. The first accepted write is the clk edge after rst deasserts.
- Write-to-flag latency: 1 edge. empty falls, and count updates, after the edge that accepts the write.
- Read latency in standard mode: data on out one edge after the accepting edge.
- Error pulses are valid in the cycle after the offending request edge.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through.
  - out = mem[rptr[AW-1:0]] combinationally whenever !empty; rd_en acknowledges and pops.
  - A word written into an empty FIFO appears on out the cycle after the write edge, with no rd_en required.
  - When empty, out holds the last presented word; it is 0 after reset.
- FIFO_FWFT_EN undefined: standard registered-read behaviour as above.
- Flags, count and error rules are identical in both modes.

## Structure
- Shared package param_fifo_pkg:
  - clog2 constant function
  - pointer/count width derivation
  - default threshold constants
- Sub-module param_fifo_mem: DEPTH×WIDTH register array with synchronous write port and asynchronous read port. The top level owns pointers, flags and the out register.
- Target size 150–250 lines of RTL in total.

## Test plan
All scenarios use WIDTH=8 and DEPTH=16.
- Fill: write 0x01..0x10 on consecutive edges.
  - almost_full rises when count=14 and full rises at count=16.
  - A 17th write of 0xAA gives a single overflow pulse; count stays 16.
- Drain: 16 reads return 0x01..0x10 in order, one edge after each accepting edge.
  - A 17th read gives an underflow pulse, out holds 0x10 and empty=1.
  - almost_empty rises at count=2.
- Wrap-around: write 10 words, read 10, then write 12 (0x20..0x2B) and read 12.
  - Order is preserved across the pointer wrap; count returns to 0.
- Simultaneous access:
  - At full with rd_en=wr_en=1 for 4 cycles: count stays 16, there is no overflow, and the head data advances correctly.
  - At empty with both asserted: count=1 and underflow pulses once.
- Reset mid-operation: with count=7, assert rst between edges.
  - All outputs take their reset values immediately.
  - After release, writing 0x55 then reading it returns 0x55.
- FWFT build (FIFO_FWFT_EN): write 0x5A into an empty FIFO.
  - out=0x5A the next cycle with rd_en=0.
  - A single rd_en pop gives empty=1.
